// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, SCL phase ticks and divider math.
// Used by the burst master and the phase-tick generator.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, START, DEV_W, ACK_CHK, ADDR_H, ADDR_L,
    WR_BYTE, RESTART, DEV_R, RD_BYTE, MST_ACK, STOP
  } state_t;

  // One SCL period = SET (scl low), RISE, SAMP (mid-high), FALL.
  typedef enum logic [1:0] {
    PH_SET, PH_RISE, PH_SAMP, PH_FALL
  } phase_t;

  function automatic int calc_div(input int clk_hz, input int scl_hz);
    return clk_hz / (4 * scl_hz);
  endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// Phase-tick generator: one tick every DIV clocks, cycling four SCL phases.
// Held at phase SET with a cleared counter while disabled.
module i2c_clk_div
  import i2c_pkg::*;
#(
  parameter int DIV = 50
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  output logic   tick_o,
  output phase_t phase_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  phase_t        ph_q;
  logic          wrap;

  assign wrap    = (cnt_q == CW'(DIV - 1));
  assign tick_o  = en_i && wrap;
  assign phase_o = ph_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ph_q  <= PH_SET;
    end else if (!en_i) begin
      cnt_q <= '0;
      ph_q  <= PH_SET;
    end else if (wrap) begin
      cnt_q <= '0;
      ph_q  <= phase_t'(ph_q + 2'd1);
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_burst_master.sv
// I2C burst master: addressed write bursts and random-read bursts
// with open-drain SDA, push-pull SCL and sticky NACK reporting.
module i2c_burst_master
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int I2C_FREQ   = 250_000,
  parameter int ADDR_BYTES = 2,
  parameter int LEN_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       dev_addr,
  input  logic [15:0]      word_addr,
  input  logic [LEN_W-1:0] len_m1,
  output logic             wr_req,
  input  logic [7:0]       wr_data,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             ack_err,
  output logic             scl,
  inout  wire              sda
);

  localparam int DIV = calc_div(CLK_FREQ, I2C_FREQ);

  state_t           state_q, from_q;
  logic             rw_q, ld_q, nack_q;
  logic [6:0]       dev_q;
  logic [15:0]      wa_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       sh_q, rdd_q;
  logic             sda_lo_q, scl_q;
  logic             busy_q, done_q, wrreq_q, rdv_q, err_q;
  logic             tick, sda_in, last;
  phase_t           ph;

  i2c_clk_div #(.DIV(DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .en_i   (busy_q),
    .tick_o (tick),
    .phase_o(ph)
  );

  assign sda      = sda_lo_q ? 1'b0 : 1'bz;
  assign sda_in   = sda;
  assign last     = (cnt_q == len_q);
  assign scl      = scl_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_req   = wrreq_q;
  assign rd_valid = rdv_q;
  assign rd_data  = rdd_q;
  assign ack_err  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      from_q   <= IDLE;
      rw_q     <= 1'b0;
      ld_q     <= 1'b0;
      nack_q   <= 1'b0;
      dev_q    <= '0;
      wa_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      rdd_q    <= '0;
      sda_lo_q <= 1'b0;
      scl_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrreq_q  <= 1'b0;
      rdv_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wrreq_q <= 1'b0;
      rdv_q   <= 1'b0;
      ld_q    <= 1'b0;
      if (ld_q) sh_q <= wr_data;
      if (state_q == IDLE) begin
        if (start) begin
          state_q <= START;
          busy_q  <= 1'b1;
          err_q   <= 1'b0;
          rw_q    <= rw;
          dev_q   <= dev_addr;
          wa_q    <= word_addr;
          len_q   <= len_m1;
          cnt_q   <= '0;
          bit_q   <= '0;
        end
      end else if (tick) begin
        unique case (ph)
          PH_SET: begin
            unique case (state_q)
              START, RESTART, ACK_CHK, RD_BYTE: sda_lo_q <= 1'b0;
              STOP:    sda_lo_q <= 1'b1;
              MST_ACK: sda_lo_q <= !last;
              default: sda_lo_q <= !sh_q[7];
            endcase
          end
          PH_RISE: scl_q <= 1'b1;
          PH_SAMP: begin
            unique case (state_q)
              START, RESTART: sda_lo_q <= 1'b1;
              STOP:    sda_lo_q <= 1'b0;
              ACK_CHK: nack_q <= sda_in;
              RD_BYTE: begin
                sh_q <= {sh_q[6:0], sda_in};
                if (bit_q == 3'd7) begin
                  rdd_q <= {sh_q[6:0], sda_in};
                  rdv_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
          PH_FALL: begin
            scl_q <= (state_q == STOP);
            unique case (state_q)
              STOP: begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
              START: begin
                state_q <= DEV_W;
                sh_q    <= {dev_q, 1'b0};
              end
              RESTART: begin
                state_q <= DEV_R;
                sh_q    <= {dev_q, 1'b1};
              end
              RD_BYTE: begin
                bit_q <= bit_q + 3'd1;
                if (bit_q == 3'd7) state_q <= MST_ACK;
              end
              MST_ACK: begin
                if (last) begin
                  state_q <= STOP;
                end else begin
                  cnt_q   <= cnt_q + 1'b1;
                  state_q <= RD_BYTE;
                end
              end
              ACK_CHK: begin
                if (nack_q) begin
                  err_q   <= 1'b1;
                  state_q <= STOP;
                end else begin
                  unique case (from_q)
                    DEV_W: begin
                      state_q <= (ADDR_BYTES == 2) ? ADDR_H : ADDR_L;
                      sh_q    <= (ADDR_BYTES == 2) ? wa_q[15:8] : wa_q[7:0];
                    end
                    ADDR_H: begin
                      state_q <= ADDR_L;
                      sh_q    <= wa_q[7:0];
                    end
                    ADDR_L: begin
                      state_q <= rw_q ? RESTART : WR_BYTE;
                      wrreq_q <= !rw_q;
                      ld_q    <= !rw_q;
                    end
                    WR_BYTE: begin
                      if (last) begin
                        state_q <= STOP;
                      end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= WR_BYTE;
                        wrreq_q <= 1'b1;
                        ld_q    <= 1'b1;
                      end
                    end
                    DEV_R:   state_q <= RD_BYTE;
                    default: state_q <= STOP;
                  endcase
                end
              end
              default: begin
                sh_q  <= {sh_q[6:0], 1'b0};
                bit_q <= bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                  state_q <= ACK_CHK;
                  from_q  <= state_q;
                end
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
